// File: rtl/tx_uart.sv
// tx_uart: UART transmitter paced by a 16x baud tick; start bit, NB_DATA bits LSB first, stop.
// Define TX_UART_PARITY_EN to insert an even-parity bit between the data and stop bits.
module tx_uart #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_COUNT = 5,
  parameter int NB_STATE = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done_tick,
  output logic               o_busy
);

  localparam int NB_BIT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [NB_COUNT-1:0] LAST_TICK = NB_COUNT'(15);
  localparam logic [NB_COUNT-1:0] STOP_LAST = NB_COUNT'(SB_TICK - 1);
  localparam logic [NB_BIT-1:0]   LAST_BIT  = NB_BIT'(NB_DATA - 1);

  typedef enum logic [NB_STATE-1:0] {
    IDLE   = NB_STATE'(0),
    START  = NB_STATE'(1),
    DATA   = NB_STATE'(2),
    STOP   = NB_STATE'(3)
`ifdef TX_UART_PARITY_EN
    , PARITY = NB_STATE'(4)
`endif
  } state_t;

  state_t               state, state_next;
  logic [NB_COUNT-1:0]  s, s_next;
  logic [NB_BIT-1:0]    n, n_next;
  logic [NB_DATA-1:0]   b, b_next;
  logic                 tx_next, busy_next, done_next;
`ifdef TX_UART_PARITY_EN
  logic                 parity, parity_next;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      b              <= '0;
      o_tx           <= 1'b1;
      o_busy         <= 1'b0;
      o_tx_done_tick <= 1'b0;
`ifdef TX_UART_PARITY_EN
      parity         <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      s              <= s_next;
      n              <= n_next;
      b              <= b_next;
      o_tx           <= tx_next;
      o_busy         <= busy_next;
      o_tx_done_tick <= done_next;
`ifdef TX_UART_PARITY_EN
      parity         <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    busy_next  = o_busy;
    done_next  = 1'b0;
    tx_next    = 1'b1;
`ifdef TX_UART_PARITY_EN
    parity_next = parity;
`endif
    case (state)
      IDLE: begin
        // the tick is deliberately ignored in the accept cycle
        if (i_tx_start) begin
          b_next     = i_data;
          s_next     = '0;
          n_next     = '0;
          busy_next  = 1'b1;
          state_next = START;
`ifdef TX_UART_PARITY_EN
          parity_next = ^i_data;
`endif
        end
      end
      START: begin
        if (i_tick) begin
          if (s == LAST_TICK) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + NB_COUNT'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s == LAST_TICK) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == LAST_BIT) begin
`ifdef TX_UART_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + NB_BIT'(1);
            end
          end else begin
            s_next = s + NB_COUNT'(1);
          end
        end
      end
`ifdef TX_UART_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (s == LAST_TICK) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + NB_COUNT'(1);
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (s == STOP_LAST) begin
            s_next     = '0;
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            s_next = s + NB_COUNT'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // line value is registered from the upcoming state so each bit edge follows its tick by one clock
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef TX_UART_PARITY_EN
      PARITY:  tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

endmodule
